// File: rtl/fetch_queue_frontend.sv
// Fetch front end: owns the PC, issues 1-cycle-latency imem reads, and buffers
// {pc,instr} responses in a FIFO that feeds decode over a valid/ready handshake.
module fetch_queue_frontend #(
    parameter int               XLEN     = 32,
    parameter int               PC_STEP  = 4,
    parameter logic [XLEN-1:0]  RESET_PC = '0,
    parameter int               QDEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        nrst,
    input  logic                        i_redirect_valid,
    input  logic [XLEN-1:0]             i_redirect_pc,
    output logic                        o_imem_req,
    output logic [XLEN-1:0]             o_imem_addr,
    input  logic [XLEN-1:0]             i_imem_rdata,
    output logic                        o_out_valid,
    input  logic                        i_out_ready,
    output logic [XLEN-1:0]             o_out_pc,
    output logic [XLEN-1:0]             o_out_instr,
    output logic [$clog2(QDEPTH):0]     o_q_count
);
    localparam int AW = $clog2(QDEPTH);
    localparam int CW = AW + 1;

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_req_pc;
    logic            r_inflight;
    logic [XLEN-1:0] r_mem_pc    [QDEPTH];
    logic [XLEN-1:0] r_mem_instr [QDEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;

    logic [CW-1:0]   w_occ;
    logic            w_req;
    logic            w_push;
    logic            w_pop;

    // Credit counts the in-flight fetch so a response always has a free slot.
    assign w_occ  = r_count + {{(CW-1){1'b0}}, r_inflight};
    assign w_req  = nrst && !i_redirect_valid && (w_occ < CW'(QDEPTH));
    assign w_push = r_inflight;
    assign w_pop  = (r_count != '0) && i_out_ready;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_pc       <= RESET_PC;
            r_req_pc   <= '0;
            r_inflight <= 1'b0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                r_mem_pc[i]    <= '0;
                r_mem_instr[i] <= '0;
            end
        end else if (i_redirect_valid) begin
            // Flush: queued entries and the in-flight response are dropped.
            r_pc       <= i_redirect_pc;
            r_inflight <= 1'b0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
        end else begin
            r_inflight <= w_req;
            if (w_req) begin
                r_pc     <= r_pc + XLEN'(PC_STEP);
                r_req_pc <= r_pc;
            end
            if (w_push) begin
                r_mem_pc[r_wptr]    <= r_req_pc;
                r_mem_instr[r_wptr] <= i_imem_rdata;
                r_wptr              <= r_wptr + AW'(1);
            end
            if (w_pop)
                r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_imem_req  = w_req;
    assign o_imem_addr = r_pc;
    assign o_out_valid = (r_count != '0);
    assign o_out_pc    = r_mem_pc[r_rptr];
    assign o_out_instr = r_mem_instr[r_rptr];
    assign o_q_count   = r_count;
endmodule
